// File: rtl/ascii_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascii_uart_pkg
// Description : Shared types and constants for the ASCII UART transmitter.
//               Holds the transmit FSM state encoding and the 8N1 frame
//               geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ascii_uart_pkg;

    // Number of payload bits per character and total bits per 8N1 frame
    // (start + data + stop).
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Transmit FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO with a combinational head read.
//               The head entry is always visible on pop_data, so a pop and
//               the consumer's capture of pop_data happen on the same edge.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset (clears pointers)
//               push      - write push_data at the tail (ignored when full)
//               push_data - byte to enqueue
//               pop       - drop the head entry (ignored when empty)
//               pop_data  - current head entry
//               count     - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import ascii_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] pop_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]  c_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_PTR_W:0]          r_count;
    logic                      w_do_push;
    logic                      w_do_pop;

    // Guard locally as well so the FIFO can never corrupt itself even if a
    // caller ignores occupancy.
    assign w_do_push = push && (r_count != c_FULL);
    assign w_do_pop  = pop  && (r_count != '0);

    // Storage is not reset: contents are only observable through valid
    // pointers, and reset clears those.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/ascii_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : ascii_uart_tx
// Description : Buffers an ASCII byte stream in a small FIFO and serialises
//               each byte as an 8N1 UART frame, LSB first. Frames are sent
//               back to back with no idle gap while bytes are queued.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - upstream byte valid
//               in_data    - upstream ASCII byte
//               in_ready   - FIFO can accept a byte
//               tx         - UART serial line, idle high (registered)
//               busy       - frame in progress or FIFO non-empty
//               fifo_count - current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_uart_tx
    import ascii_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [UART_DATA_BITS-1:0]     in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                  c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0]  c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_BAUD_ONE  = c_CNT_W'(1);
    localparam int                  c_FCNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(FIFO_DEPTH);
    localparam logic [2:0]          c_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state;
    uart_state_t               w_state_nxt;
    logic [c_CNT_W-1:0]        r_baud_cnt;
    logic [c_CNT_W-1:0]        w_baud_nxt;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      r_tx;
    logic                      w_tx_nxt;

    logic                      w_push;
    logic                      w_pop;
    logic [UART_DATA_BITS-1:0] w_pop_data;
    logic [c_FCNT_W-1:0]       w_fifo_count;
    logic                      w_fifo_nonempty;
    logic                      w_bit_end;

    // Ready looks only at the registered count, so a pop on the same edge
    // never opens an extra slot combinationally.
    assign in_ready        = (w_fifo_count != c_FIFO_FULL);
    assign w_push          = in_valid && in_ready;
    assign w_fifo_nonempty = (w_fifo_count != '0);
    assign w_bit_end       = (r_baud_cnt == c_BAUD_LAST);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // tx is computed one cycle ahead so the pin itself is a flop output.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_pop_data;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        // Next bit is shift[1] before the shift lands.
                        w_shift_nxt = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when data waits.
                    if (w_fifo_nonempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_pop_data;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || w_fifo_nonempty;
    assign fifo_count = w_fifo_count;

endmodule
`default_nettype wire
